pe_add_feeder: RTL and testbench

- Front-end sequencer for the 8-bit adder PE: the writer side of the PE's `en`/`a`/`b` operand interface.
- Buffers operand pairs from upstream in a small FIFO and issues them to the PE with a single-cycle `pe_en`.
- Tracks the PE's one-cycle result latency and presents each result downstream on a valid/ready port.
- Sustains one operation per cycle when downstream does not stall.

---
 rtl/pe_add_feeder.sv | 119 +++++++++++
 tb/tb_pe_add_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_add_feeder.sv
// Operand FIFO feeding a 1-cycle adder PE, with a 1-deep result slot presented on valid/ready.
// Latency: push at edge N -> issue cycle N+1 -> result valid cycle N+2; a stalled result blocks issue while the FIFO fills.
module pe_add_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    output logic                     pe_en,
    output logic [DATA_W-1:0]        pe_a,
    output logic [DATA_W-1:0]        pe_b,
    input  logic [DATA_W-1:0]        pe_add,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         done_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;
    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_a_d [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic [DATA_W-1:0] mem_b_d [DEPTH];

    logic push;
    logic issue;
    logic handshake;

    assign in_ready   = !flush && (count_q != FULL);
    assign push       = in_valid && in_ready;
    assign handshake  = pending_q && out_ready;
    // A new operation may only enter the PE when the current result leaves this cycle.
    assign issue      = !flush && (count_q != '0) && (!pending_q || out_ready);

    assign pe_en      = issue;
    assign pe_a       = mem_a_q[rd_ptr_q];
    assign pe_b       = mem_b_q[rd_ptr_q];
    assign out_valid  = pending_q;
    assign out_data   = pe_add;
    assign fifo_count = count_q;
    assign done_cnt   = done_cnt_q;

    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pending_d  = pending_q;
        done_cnt_d = done_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            pending_d  = 1'b0;
            done_cnt_d = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (issue)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, issue})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (issue)
                pending_d = 1'b1;
            else if (handshake)
                pending_d = 1'b0;
            if (handshake)
                done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Operand storage carries no reset; its contents are only read behind count_q.
    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

endmodule

// File: tb/tb_pe_add_feeder.sv
// Bench for pe_add_feeder: models the adder PE and checks results against arithmetic expectations.
module tb_pe_add_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a, in_b;
    logic              pe_en;
    logic [DATA_W-1:0] pe_a, pe_b;
    logic [DATA_W-1:0] pe_add;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        fifo_count;
    logic [CNT_W-1:0]  done_cnt;

    int checks = 0;
    int passed = 0;
    int hs_total = 0;
    int en_cnt = 0;
    logic [DATA_W-1:0] got_q[$];

    always #5 clk = ~clk;

    pe_add_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b), .pe_add(pe_add),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count), .done_cnt(done_cnt)
    );

    // Adder PE: registered sum captured on en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_add <= '0;
        else if (pe_en) pe_add <= pe_a + pe_b;
    end

    // Records every accepted result and every PE enable.
    always @(posedge clk) begin
        if (rst_n) begin
            if (pe_en) en_cnt++;
            if (flush) hs_total = 0;
            else if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                hs_total++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (pe_en !== 1'b0) $display("FAIL reset_pe_en got=%b exp=0", pe_en); else passed++;
        checks++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        checks++; if (done_cnt !== 16'd0) $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); else passed++;
        rst_n = 1'b1;
        hs_total = 0; en_cnt = 0; got_q.delete();
        @(negedge clk);
    endtask

    task automatic test_single();
        got_q.delete();
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (pe_en !== 1'b1) $display("FAIL single_pe_en got=%b exp=1", pe_en); else passed++;
        checks++; if (pe_a !== 8'd3 || pe_b !== 8'd4) $display("FAIL single_operands got=%0d,%0d exp=3,4", pe_a, pe_b); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", out_valid); else passed++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd7) $display("FAIL single_result got=%b/%0d exp=1/7", out_valid, out_data); else passed++;
        checks++; if (pe_en !== 1'b0) $display("FAIL single_pe_en_pulse got=%b exp=0", pe_en); else passed++;
        @(negedge clk);
        checks++; if (done_cnt !== 16'd1) $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL single_valid_drop got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_stream();
        int run = 0, best = 0, bad = 0;
        int en_before = en_cnt;
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 8); in_a = DATA_W'(i); in_b = DATA_W'(i);
            @(negedge clk);
            if (pe_en) run++; else run = 0;
            if (run > best) best = run;
        end
        in_valid = 1'b0;
        checks++; if (best !== 8) $display("FAIL stream_pe_en_run got=%0d exp=8", best); else passed++;
        checks++; if (en_cnt - en_before !== 8) $display("FAIL stream_issue_count got=%0d exp=8", en_cnt - en_before); else passed++;
        checks++; if (got_q.size() !== 8) $display("FAIL stream_result_count got=%0d exp=8", got_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < 8; i++)
            if (got_q[i] !== DATA_W'(2 * i)) bad++;
        checks++; if (bad !== 0) $display("FAIL stream_values got=%0d wrong exp=0 wrong", bad); else passed++;
        checks++; if (done_cnt !== CNT_W'(hs_total)) $display("FAIL stream_done_cnt got=%0d exp=%0d", done_cnt, hs_total); else passed++;
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp_sum;
        exp_sum = DATA_W'((200 + 100) % 256);
        out_ready = 1'b1; in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== exp_sum) $display("FAIL overflow_sum got=%b/%0d exp=1/%0d", out_valid, out_data, exp_sum); else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_q[$];
        int bad = 0, k = 0;
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
            exp_q.push_back(in_a + in_b);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (fifo_count !== 3'd4) $display("FAIL bp_fifo_count got=%0d exp=4", fifo_count); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) $display("FAIL bp_held got=%b/%0d exp=1/%0d", out_valid, out_data, exp_q[0]); else passed++;
        repeat (3) begin
            @(negedge clk);
            if (pe_en !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_q[0]) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad); else passed++;
        out_ready = 1'b1;
        while (k < 20 && (out_valid || fifo_count != 0)) begin
            @(negedge clk); k++;
        end
        checks++; if (k >= 20) $display("FAIL bp_drain_timeout got=%0d cycles exp=<20", k); else passed++;
        checks++; if (fifo_count !== 3'd0) $display("FAIL bp_fifo_empty got=%0d exp=0", fifo_count); else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad !== 0 || got_q.size() !== 5) $display("FAIL bp_order got=%0d results %0d wrong exp=5 results 0 wrong", got_q.size(), bad); else passed++;
    endtask

    task automatic test_flush();
        int en_before;
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3 || out_valid !== 1'b1) $display("FAIL flush_setup got=%0d/%b exp=3/1", fifo_count, out_valid); else passed++;
        en_before = en_cnt;
        flush = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || pe_en !== 1'b0) $display("FAIL flush_blocks got=%b/%b exp=0/0", in_ready, pe_en); else passed++;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL flush_clear got=%b/%0d exp=0/0", out_valid, fifo_count); else passed++;
        checks++; if (done_cnt !== 16'd0) $display("FAIL flush_done_cnt got=%0d exp=0", done_cnt); else passed++;
        checks++; if (got_q.size() !== 0) $display("FAIL flush_dropped got=%0d results exp=0", got_q.size()); else passed++;
        @(negedge clk);
        checks++; if (en_cnt !== en_before) $display("FAIL flush_no_issue got=%0d exp=%0d", en_cnt, en_before); else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) out_ready = 1'b0;
            in_valid = 1'b1; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || done_cnt !== CNT_W'(hs_total) || hs_total == 0)
            $display("FAIL areset_setup got=%b/%0d exp=1/%0d(nonzero)", out_valid, done_cnt, hs_total); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || pe_en !== 1'b0) $display("FAIL areset_outputs got=%b/%b exp=0/0", out_valid, pe_en); else passed++;
        checks++; if (fifo_count !== 3'd0 || done_cnt !== 16'd0) $display("FAIL areset_state got=%0d/%0d exp=0/0", fifo_count, done_cnt); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready got=%b exp=1", in_ready); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        hs_total = 0; got_q.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_q[$];
        int viol = 0, bad = 0, k = 0;
        got_q.delete();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = DATA_W'($urandom);
            in_b      = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(in_a + in_b);
            if (pe_en && out_valid && !out_ready) viol++;
            if (fifo_count > 3'd4) viol++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        while (k < 40 && (out_valid || fifo_count != 0)) begin
            @(negedge clk); k++;
        end
        checks++; if (k >= 40) $display("FAIL rand_drain_timeout got=%0d cycles exp=<40", k); else passed++;
        checks++; if (viol !== 0) $display("FAIL rand_protocol got=%0d violations exp=0", viol); else passed++;
        checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad !== 0) $display("FAIL rand_values got=%0d wrong exp=0 wrong", bad); else passed++;
        checks++; if (done_cnt !== CNT_W'(exp_q.size())) $display("FAIL rand_done_cnt got=%0d exp=%0d", done_cnt, exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_overflow();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
